clk_gen: RTL
============

CLK_GEN -- requirements
Module: clk_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the phase-length fields and the phase counter.
REQ-002 The module SHALL have parameter PCNT_W, default 16, giving the width of the completed-period counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The module SHALL have port cfg_valid, input, 1 bit: a new high/low configuration is offered.
REQ-006 The module SHALL have port cfg_ready, output, 1 bit: the pending-configuration slot is free.
REQ-007 The module SHALL have port cfg_high, input, CNT_W bits: high-phase length in clk cycles.
REQ-008 The module SHALL have port cfg_low, input, CNT_W bits: low-phase length in clk cycles.
REQ-009 The module SHALL have port enable, input, 1 bit: a request to run the generated clock.
REQ-010 The module SHALL have port clk_out, output, 1 bit: the generated clock, driven from a register.
REQ-011 The module SHALL have port rise_pulse, output, 1 bit: a one-cycle strobe in the first cycle clk_out is 1 in each period.
REQ-012 The module SHALL have port fall_pulse, output, 1 bit: a one-cycle strobe in the first cycle clk_out is 0 after a high phase.
REQ-013 The module SHALL have port period_cnt, output, PCNT_W bits: the number of completed periods.
REQ-014 The module SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, HIGH and LOW, and clk_out SHALL be 1 only in HIGH.
REQ-016 A configuration SHALL be accepted on any cycle in which cfg_valid and cfg_ready are both 1; the accepted values SHALL be stored in a pending register.
REQ-017 cfg_ready SHALL be 0 from the cycle after acceptance until the cycle after the pending values are applied.
REQ-018 A cfg_high or cfg_low value of 0 SHALL be clamped to 1 when it is stored.
REQ-019 Pending values SHALL be applied only at a period start, so the active high/low lengths never change mid-period.
REQ-020 A period start SHALL be either the transition IDLE->HIGH or the transition LOW->HIGH.
REQ-021 IDLE->HIGH SHALL occur when enable=1 and either an active or a pending configuration exists.
REQ-022 In IDLE with enable=1 and no configuration ever loaded, the FSM SHALL remain in IDLE.
REQ-023 On entry to HIGH, the down-counter SHALL be set to H-1; on entry to LOW, it SHALL be set to L-1.
REQ-024 In HIGH with counter 0, the FSM SHALL go to LOW; otherwise the counter SHALL decrement.
REQ-025 In LOW with counter 0, the FSM SHALL increment period_cnt and then go to HIGH if enable=1, or to IDLE otherwise.
REQ-026 With configuration (H, L), clk_out SHALL be high for exactly H cycles and low for exactly L cycles, giving a period of H+L cycles.
REQ-027 Deasserting enable mid-period SHALL complete the current period, so that no runt pulse is generated.
REQ-028 period_cnt SHALL wrap from 2^PCNT_W-1 to 0.
REQ-029 rise_pulse and fall_pulse SHALL be registered and aligned with the clk_out edge they mark.
REQ-030 The latency from enable rising (with a configuration present) to clk_out=1 SHALL be 1 cycle.

Reset
REQ-031 When rst_n=0 at a clk edge, the module SHALL set state=IDLE, clk_out=0, rise_pulse=0, fall_pulse=0, busy=0, period_cnt=0 and cfg_ready=1.
REQ-032 Reset SHALL also clear the active and pending configurations and their valid flags.
REQ-033 Reset SHALL take precedence over every other input, including when asserted mid-period.

Structure
REQ-034 Package clk_gen_pkg SHALL hold the state enum and the default CNT_W and PCNT_W constants.
REQ-035 A single sub-module, clk_gen_phase_cnt, SHALL implement the loadable CNT_W down-counter with a zero flag; the FSM and configuration registers SHALL be in clk_gen.

Verification
REQ-036 Reset, load 3/5, enable=1 -> clk_out pattern 1,1,1,0,0,0,0,0 repeating; rise_pulse every 8 cycles; period_cnt=2 after 16 cycles.
REQ-037 Load 1/1 -> clk_out toggles every cycle; rise_pulse on alternate cycles.
REQ-038 Load 0/4 -> clamped to 1/4; period of 5 cycles with a high time of 1.
REQ-039 Running 3/5, offer 2/2 during HIGH -> cfg_ready=0; current period stays 3/5; next period is 2/2; cfg_ready=1 after the switch.
REQ-040 Drop enable during HIGH of 3/5 -> period completes (3 high, 5 low); then IDLE, busy=0, clk_out=0, period_cnt incremented by 1.
REQ-041 rst_n=0 mid-LOW, then enable=1 with no configuration -> all outputs 0 and cfg_ready=1; remains IDLE until a configuration is loaded.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and default widths for the programmable clock generator
package clk_gen_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_PCNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/clk_gen_if.sv
// rtl/clk_gen_if.sv - configuration/control bundle for the programmable clock generator
interface clk_gen_if
    import clk_gen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PCNT_W = DEF_PCNT_W
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_low;
    logic              enable;
    logic              clk_out;
    logic              rise_pulse;
    logic              fall_pulse;
    logic [PCNT_W-1:0] period_cnt;
    logic              busy;

    modport master (
        output cfg_valid, cfg_high, cfg_low, enable,
        input  cfg_ready, clk_out, rise_pulse, fall_pulse, period_cnt, busy
    );

    modport slave (
        input  cfg_valid, cfg_high, cfg_low, enable,
        output cfg_ready, clk_out, rise_pulse, fall_pulse, period_cnt, busy
    );

endinterface

// File: rtl/clk_gen_phase_cnt.sv
// rtl/clk_gen_phase_cnt.sv - loadable phase down-counter with zero flag
module clk_gen_phase_cnt
    import clk_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gen.sv
// rtl/clk_gen.sv - programmable high/low clock generator with glitch-free reconfiguration
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PCNT_W = DEF_PCNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic              enable,
    output logic              clk_out,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [PCNT_W-1:0] period_cnt,
    output logic              busy
);

    state_e            state_q;
    state_e            state_d;

    logic [CNT_W-1:0]  act_high_q;
    logic [CNT_W-1:0]  act_low_q;
    logic              act_valid_q;
    logic [CNT_W-1:0]  pend_high_q;
    logic [CNT_W-1:0]  pend_low_q;
    logic              pend_valid_q;
    logic [PCNT_W-1:0] period_cnt_q;
    logic              clk_out_q;
    logic              rise_q;
    logic              fall_q;

    logic              cfg_accept;
    logic              cfg_avail;
    logic [CNT_W-1:0]  next_high;
    logic              start_period;
    logic              period_done;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_dec;
    logic              cnt_zero;

    assign cfg_ready  = !pend_valid_q;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_avail  = act_valid_q || pend_valid_q;
    // A pending configuration always wins at a period start.
    assign next_high  = pend_valid_q ? pend_high_q : act_high_q;

    clk_gen_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_period = 1'b0;
        period_done  = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && cfg_avail) begin
                    state_d      = ST_HIGH;
                    start_period = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_val      = next_high - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d  = ST_LOW;
                    cnt_load = 1'b1;
                    cnt_val  = act_low_q - CNT_W'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    period_done = 1'b1;
                    if (enable) begin
                        state_d      = ST_HIGH;
                        start_period = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_val      = next_high - CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_high_q   <= '0;
            act_low_q    <= '0;
            act_valid_q  <= 1'b0;
            pend_high_q  <= '0;
            pend_low_q   <= '0;
            pend_valid_q <= 1'b0;
            period_cnt_q <= '0;
            clk_out_q    <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            if (start_period && pend_valid_q) begin
                act_high_q  <= pend_high_q;
                act_low_q   <= pend_low_q;
                act_valid_q <= 1'b1;
            end
            // Accept only happens with the slot empty, so it never collides with a pending apply.
            if (cfg_accept) begin
                pend_high_q  <= (cfg_high == '0) ? CNT_W'(1) : cfg_high;
                pend_low_q   <= (cfg_low == '0) ? CNT_W'(1) : cfg_low;
                pend_valid_q <= 1'b1;
            end else if (start_period) begin
                pend_valid_q <= 1'b0;
            end
            if (period_done) begin
                period_cnt_q <= period_cnt_q + PCNT_W'(1);
            end
            clk_out_q <= (state_d == ST_HIGH);
            rise_q    <= start_period;
            fall_q    <= (state_q == ST_HIGH) && (state_d == ST_LOW);
        end
    end

    assign clk_out    = clk_out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign period_cnt = period_cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
